// File: rtl/icache_responder.sv
// Read-only direct-mapped instruction cache: answers fetch requests from the
// fetcher and refills missing lines with a fixed-length burst from memory.
module icache_responder #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int LINE_WORDS = 8,
    parameter int NUM_LINES  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  read_enable,
    input  logic                  invalidate,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  data_valid,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int BYTE_W = $clog2(DATA_WIDTH / 8);
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = ADDR_WIDTH - IDX_W - OFF_W - BYTE_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        FILL_REQ,
        FILL_WAIT,
        RESPOND
    } state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] data_arr [NUM_LINES*LINE_WORDS];
    logic [TAG_W-1:0]      tag_arr  [NUM_LINES];
    logic [NUM_LINES-1:0]  valid;
    logic [OFF_W-1:0]      beat_cnt;
    logic                  kill;
    logic [DATA_WIDTH-1:0] read_hold;

    logic [OFF_W-1:0]      req_off;
    logic [IDX_W-1:0]      req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [DATA_WIDTH-1:0] word;
    logic                  hit;
    logic                  beat_in;
    logic                  last_beat;
    logic                  unused_addr_bits;

    assign req_off   = req_addr[BYTE_W +: OFF_W];
    assign req_idx   = req_addr[BYTE_W+OFF_W +: IDX_W];
    assign req_tag   = req_addr[ADDR_WIDTH-1 -: TAG_W];
    assign word      = data_arr[{req_idx, req_off}];
    assign hit       = valid[req_idx] && (tag_arr[req_idx] == req_tag);
    assign beat_in   = (state == FILL_WAIT) && mem_rvalid;
    assign last_beat = beat_in && (beat_cnt == OFF_W'(LINE_WORDS - 1));

    // Byte-within-word bits never select anything.
    assign unused_addr_bits = ^address[BYTE_W-1:0];

    always_comb begin
        state_next = state;
        data_valid = 1'b0;
        mem_req    = 1'b0;
        case (state)
            IDLE:      if (read_enable) state_next = LOOKUP;
            LOOKUP: begin
                if (hit) begin
                    data_valid = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = FILL_REQ;
                end
            end
            FILL_REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) state_next = FILL_WAIT;
            end
            FILL_WAIT: if (last_beat) state_next = RESPOND;
            RESPOND: begin
                // The final beat was written on the edge that entered this state.
                data_valid = 1'b1;
                state_next = IDLE;
            end
            default:   state_next = IDLE;
        endcase
        read_data = data_valid ? word : read_hold;
        mem_addr  = mem_req ? {req_tag, req_idx, {(BYTE_W+OFF_W){1'b0}}} : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            valid     <= '0;
            beat_cnt  <= '0;
            kill      <= 1'b0;
            read_hold <= '0;
        end else begin
            state <= state_next;
            if (data_valid) read_hold <= word;
            if (last_beat)    beat_cnt <= '0;
            else if (beat_in) beat_cnt <= beat_cnt + 1'b1;
            // Kill remembers an invalidate that raced an in-flight fill.
            if (state_next == IDLE)
                kill <= 1'b0;
            else if (invalidate && (state == FILL_REQ || state == FILL_WAIT))
                kill <= 1'b1;
            if (invalidate)
                valid <= '0;
            else if (last_beat && !kill)
                valid[req_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && read_enable) req_addr <= address;
        if (beat_in && !reset) data_arr[{req_idx, beat_cnt}] <= mem_rdata;
        if (last_beat && !reset) tag_arr[req_idx] <= req_tag;
    end

endmodule

// File: tb/tb_icache_responder.sv
// Scoreboard bench for icache_responder: a scripted memory model serves fills
// and each scenario compares returned words against queued expectations.
module tb_icache_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] address;
    logic        read_enable;
    logic        invalidate;
    logic [63:0] read_data;
    logic        data_valid;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp;

    icache_responder dut (
        .clk(clk), .reset(reset), .address(address), .read_enable(read_enable),
        .invalidate(invalidate), .read_data(read_data), .data_valid(data_valid),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single accept edge, then scramble the address.
    task automatic issue(input logic [63:0] a);
        address = a;
        read_enable = 1'b1;
        step();
        read_enable = 1'b0;
        address = 64'hFFFF_FFFF_FFFF_FFF8;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic grant();
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
    endtask

    task automatic beats(input logic [63:0] base, input int first, input int last, input int gap);
        for (int i = first; i <= last; i++) begin
            if (i != first) repeat (gap) step();
            mem_rvalid = 1'b1;
            mem_rdata  = base + 64'(i);
            step();
            mem_rvalid = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; read_enable = 1'b0; invalidate = 1'b0; address = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL reset_dv: got %b want 0", data_valid); end
        vectors++; if (read_data !== 64'h0) begin miscompares++; $display("FAIL reset_rd: got %h want 0", read_data); end
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", mem_req); end
        vectors++; if (mem_addr !== 64'h0) begin miscompares++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
        step();
    endtask

    task automatic test_cold_miss();
        bit ok;
        issue(64'h1008); exp_q.push_back(64'hA1);
        @(negedge clk);
        vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL cold_lookup_dv: got %b want 0", data_valid); end
        wait_req(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL cold_req_timeout: got no mem_req want mem_req"); return; end
        vectors++; if (mem_addr !== 64'h1000) begin miscompares++; $display("FAIL cold_addr: got %h want %h", mem_addr, 64'h1000); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            vectors++; if (mem_req !== 1'b1 || mem_addr !== 64'h1000) begin miscompares++; $display("FAIL cold_hold: got req=%b addr=%h want req=1 addr=1000", mem_req, mem_addr); end
        end
        grant();
        @(negedge clk);
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL cold_req_drop: got %b want 0", mem_req); end
        beats(64'hA0, 0, 7, 0);
        @(negedge clk);
        vectors++; if (data_valid !== 1'b1) begin miscompares++; $display("FAIL cold_latency: got dv=%b want 1", data_valid); end
        exp = exp_q.pop_front();
        vectors++; if (read_data !== exp) begin miscompares++; $display("FAIL cold_data: got %h want %h", read_data, exp); end
        @(negedge clk);
        vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL cold_single_pulse: got %b want 0", data_valid); end
        vectors++; if (read_data !== 64'hA1) begin miscompares++; $display("FAIL cold_hold_rd: got %h want a1", read_data); end
        step();
    endtask

    task automatic test_hit();
        issue(64'h1038); exp_q.push_back(64'hA7);
        @(negedge clk);
        vectors++; if (data_valid !== 1'b1) begin miscompares++; $display("FAIL hit_latency: got dv=%b want 1", data_valid); end
        exp = exp_q.pop_front();
        vectors++; if (read_data !== exp) begin miscompares++; $display("FAIL hit_data: got %h want %h", read_data, exp); end
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL hit_no_req: got %b want 0", mem_req); end
        @(negedge clk);
        vectors++; if (data_valid !== 1'b0 || mem_req !== 1'b0) begin miscompares++; $display("FAIL hit_after: got dv=%b req=%b want 0 0", data_valid, mem_req); end
        step();
    endtask

    task automatic test_back_to_back();
        address = 64'h1010; read_enable = 1'b1; exp_q.push_back(64'hA2);
        step();
        address = 64'h1018; exp_q.push_back(64'hA3);
        @(negedge clk);
        exp = exp_q.pop_front();
        vectors++; if (data_valid !== 1'b1 || read_data !== exp) begin miscompares++; $display("FAIL b2b_first: got dv=%b rd=%h want 1 %h", data_valid, read_data, exp); end
        @(negedge clk);
        vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_gap: got %b want 0", data_valid); end
        @(negedge clk);
        read_enable = 1'b0;
        exp = exp_q.pop_front();
        vectors++; if (data_valid !== 1'b1 || read_data !== exp) begin miscompares++; $display("FAIL b2b_second: got dv=%b rd=%h want 1 %h", data_valid, read_data, exp); end
        step();
    endtask

    task automatic test_conflict_invalidate();
        bit ok;
        issue(64'h2000); exp_q.push_back(64'hB0);
        @(negedge clk);
        vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL conf_lookup_dv: got %b want 0", data_valid); end
        wait_req(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL conf_req_timeout: got no mem_req want mem_req"); return; end
        vectors++; if (mem_addr !== 64'h2000) begin miscompares++; $display("FAIL conf_addr: got %h want 2000", mem_addr); end
        grant();
        beats(64'hB0, 0, 7, 1);
        @(negedge clk);
        exp = exp_q.pop_front();
        vectors++; if (data_valid !== 1'b1 || read_data !== exp) begin miscompares++; $display("FAIL conf_data: got dv=%b rd=%h want 1 %h", data_valid, read_data, exp); end
        step();
        // 0x1000 was evicted by the conflict; its refill is killed midway.
        issue(64'h1000); exp_q.push_back(64'hA0);
        @(negedge clk);
        vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL evicted_miss: got dv=%b want 0", data_valid); end
        wait_req(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL evicted_req_timeout: got no mem_req want mem_req"); return; end
        vectors++; if (mem_addr !== 64'h1000) begin miscompares++; $display("FAIL evicted_addr: got %h want 1000", mem_addr); end
        grant();
        beats(64'hA0, 0, 3, 0);
        invalidate = 1'b1;
        step();
        invalidate = 1'b0;
        beats(64'hA0, 4, 7, 0);
        @(negedge clk);
        exp = exp_q.pop_front();
        vectors++; if (data_valid !== 1'b1 || read_data !== exp) begin miscompares++; $display("FAIL killed_data: got dv=%b rd=%h want 1 %h", data_valid, read_data, exp); end
        step();
        // Killed line must miss; this refill also stalls the grant and gaps the beats.
        issue(64'h1000); exp_q.push_back(64'hC0);
        @(negedge clk);
        vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL killed_miss: got dv=%b want 0", data_valid); end
        wait_req(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL killed_req_timeout: got no mem_req want mem_req"); return; end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++; if (mem_req !== 1'b1 || mem_addr !== 64'h1000) begin miscompares++; $display("FAIL stall_hold: got req=%b addr=%h want req=1 addr=1000", mem_req, mem_addr); end
        end
        grant();
        beats(64'hC0, 0, 7, 2);
        @(negedge clk);
        exp = exp_q.pop_front();
        vectors++; if (data_valid !== 1'b1 || read_data !== exp) begin miscompares++; $display("FAIL stall_data: got dv=%b rd=%h want 1 %h", data_valid, read_data, exp); end
        @(negedge clk);
        vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL stall_single_pulse: got %b want 0", data_valid); end
        step();
        issue(64'h1008); exp_q.push_back(64'hC1);
        @(negedge clk);
        exp = exp_q.pop_front();
        vectors++; if (data_valid !== 1'b1 || read_data !== exp) begin miscompares++; $display("FAIL stall_hit: got dv=%b rd=%h want 1 %h", data_valid, read_data, exp); end
        step();
    endtask

    task automatic test_reset_mid_fill();
        bit ok;
        invalidate = 1'b1;
        step();
        invalidate = 1'b0;
        issue(64'h1000);
        @(negedge clk);
        vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL inv_idle_miss: got dv=%b want 0", data_valid); end
        wait_req(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rst_req_timeout: got no mem_req want mem_req"); return; end
        grant();
        beats(64'hE0, 0, 2, 0);
        reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'hE3;
        step();
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (data_valid !== 1'b0 || read_data !== 64'h0) begin miscompares++; $display("FAIL rst_mid_out: got dv=%b rd=%h want 0 0", data_valid, read_data); end
        vectors++; if (mem_req !== 1'b0 || mem_addr !== 64'h0) begin miscompares++; $display("FAIL rst_mid_mem: got req=%b addr=%h want 0 0", mem_req, mem_addr); end
        for (int i = 4; i <= 7; i++) begin
            mem_rvalid = 1'b1; mem_rdata = 64'hE0 + 64'(i);
            @(negedge clk);
            vectors++; if (data_valid !== 1'b0 || mem_req !== 1'b0) begin miscompares++; $display("FAIL stale_beat: got dv=%b req=%b want 0 0", data_valid, mem_req); end
            step();
        end
        mem_rvalid = 1'b0;
        issue(64'h1000); exp_q.push_back(64'hD0);
        @(negedge clk);
        vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL post_rst_miss: got dv=%b want 0", data_valid); end
        wait_req(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL post_rst_timeout: got no mem_req want mem_req"); return; end
        vectors++; if (mem_addr !== 64'h1000) begin miscompares++; $display("FAIL post_rst_addr: got %h want 1000", mem_addr); end
        grant();
        beats(64'hD0, 0, 7, 0);
        @(negedge clk);
        exp = exp_q.pop_front();
        vectors++; if (data_valid !== 1'b1 || read_data !== exp) begin miscompares++; $display("FAIL post_rst_data: got dv=%b rd=%h want 1 %h", data_valid, read_data, exp); end
        step();
        issue(64'h1018); exp_q.push_back(64'hD3);
        @(negedge clk);
        exp = exp_q.pop_front();
        vectors++; if (data_valid !== 1'b1 || read_data !== exp) begin miscompares++; $display("FAIL post_rst_hit: got dv=%b rd=%h want 1 %h", data_valid, read_data, exp); end
        step();
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_back_to_back();
        test_conflict_invalidate();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
